seq_divider: RTL and testbench

//   Iterative unsigned restoring divider, parameterised by operand width N.

---
 rtl/seq_divider_pkg.sv | 12 +
 rtl/seq_divider_div_step.sv | 25 ++
 rtl/seq_divider.sv | 120 ++++++++++++
 tb/tb_seq_divider.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encodings and the fill bit used for the divide-by-zero quotient.
package seq_divider_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A zero divisor reports a quotient of all ones, replicated to N bits.
    localparam logic DIV0_Q_BIT = 1'b1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int N = 5
) (
    input  logic [N:0]   p_in,
    input  logic         bit_in,
    input  logic [N-1:0] b,
    output logic [N:0]   p_out,
    output logic         q_bit
);

    // One extra bit above the shifted remainder acts as the borrow/sign of the trial subtraction.
    logic [N+1:0] shifted;
    logic [N+1:0] diff;

    // Shift, trial-subtract, then keep the difference or restore the shifted value.
    always_comb begin
        shifted = {p_in, bit_in};
        diff    = shifted - {2'b00, b};
        q_bit   = ~diff[N+1];
        p_out   = q_bit ? diff[N:0] : shifted[N:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, with a
// start/busy/done handshake and results held stable between completions.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int             CW        = $clog2(N);
    localparam logic [CW-1:0]  LAST_STEP = CW'(N - 1);

    logic [1:0]    state_q, state_d;
    logic [N:0]    p_q, p_d;        // partial remainder, one bit wider than B
    logic [N-1:0]  a_q, a_d;        // dividend bits shift out, quotient bits shift in
    logic [N-1:0]  b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    p_step;
    logic          q_bit;

    div_step #(.N(N)) u_step (
        .p_in   (p_q),
        .bit_in (a_q[N-1]),
        .b      (b_q),
        .p_out  (p_step),
        .q_bit  (q_bit)
    );

    // Next-state and datapath: accept in IDLE/DONE, iterate in RUN, publish results on the last step.
    always_comb begin
        // NOTE: every _d starts from its held value so no path leaves it unassigned (no latch).
        state_d = state_q;
        p_d     = p_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = dividend;
                    b_d     = divisor;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (b_q == '0) begin
                    // Zero divisor resolves on the first edge after acceptance.
                    quot_d  = {N{DIV0_Q_BIT}};
                    rem_d   = a_q;
                    dbz_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    p_d   = p_step;
                    a_d   = {a_q[N-2:0], q_bit};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        quot_d  = {a_q[N-2:0], q_bit};
                        rem_d   = p_step[N-1:0];
                        dbz_d   = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; rst aborts any operation and clears the results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state_q <= state_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=5): reset, basic division, operand
// patterns, divide-by-zero, ignored start, back-to-back, abort, full sweep.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] dividend;
    logic [4:0] divisor;
    logic       busy;
    logic       done;
    logic [4:0] quotient;
    logic [4:0] remainder;
    logic       div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    seq_divider #(.N(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Start an operation and return the number of edges until done (0 = no done within bound).
    task automatic do_op(input logic [4:0] a, input logic [4:0] b, output int lat);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic check_result(input string name, input int lat, input int exp_lat,
                                input logic [4:0] exp_q, input logic [4:0] exp_r,
                                input logic exp_dbz);
        n_cmp++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (quotient !== exp_q) begin
            n_err++;
            $display("FAIL %s quotient: got %0d expected %0d", name, quotient, exp_q);
        end
        n_cmp++;
        if (remainder !== exp_r) begin
            n_err++;
            $display("FAIL %s remainder: got %0d expected %0d", name, remainder, exp_r);
        end
        n_cmp++;
        if (div_by_zero !== exp_dbz) begin
            n_err++;
            $display("FAIL %s div_by_zero: got %0d expected %0d", name, div_by_zero, exp_dbz);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            n_err++;
            $display("FAIL reset flags: got %b expected 000", {busy, done, div_by_zero});
        end
        n_cmp++;
        if ({quotient, remainder} !== 10'd0) begin
            n_err++;
            $display("FAIL reset results: got q=%0d r=%0d expected 0/0", quotient, remainder);
        end
    endtask

    task automatic test_basic();
        int lat;
        dividend = 5'd15;
        divisor  = 5'd4;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        for (int e = 0; e <= 20; e++) begin
            if (e > 0) begin
                @(posedge clk); #1;
            end
            if (done) begin
                lat = e;
                break;
            end
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL basic busy at edge %0d: got %b expected 1", e, busy);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic busy in done cycle: got %b expected 0", busy);
        end
        check_result("15/4", lat, 5, 5'd3, 5'd3, 1'b0);
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL basic done pulse width: got %b expected 0", done);
        end
    endtask

    task automatic test_patterns();
        int lat;
        do_op(5'd31, 5'd1, lat);  check_result("31/1", lat, 5, 5'd31, 5'd0, 1'b0);
        do_op(5'd3, 5'd5, lat);   check_result("3/5", lat, 5, 5'd0, 5'd3, 1'b0);
        do_op(5'd16, 5'd16, lat); check_result("16/16", lat, 5, 5'd1, 5'd0, 1'b0);
        do_op(5'd0, 5'd7, lat);   check_result("0/7", lat, 5, 5'd0, 5'd0, 1'b0);
        do_op(5'd30, 5'd31, lat); check_result("30/31", lat, 5, 5'd0, 5'd30, 1'b0);
    endtask

    task automatic test_div_zero();
        int lat;
        do_op(5'd9, 5'd0, lat); check_result("9/0", lat, 1, 5'd31, 5'd9, 1'b1);
        do_op(5'd6, 5'd3, lat); check_result("6/3 after div0", lat, 5, 5'd2, 5'd0, 1'b0);
    endtask

    task automatic test_start_ignored_and_back_to_back();
        int lat;
        dividend = 5'd20;
        divisor  = 5'd6;
        start    = 1'b1;
        @(posedge clk); #1;          // edge 0 accepts 20/6
        start = 1'b0;
        @(posedge clk); #1;          // edge 1
        dividend = 5'd1;
        divisor  = 5'd1;
        start    = 1'b1;
        @(posedge clk); #1;          // edge 2: start while busy must be ignored
        start = 1'b0;
        n_cmp++;
        if (quotient !== 5'd2 || remainder !== 5'd0) begin
            n_err++;
            $display("FAIL ignored-start mid-run results: got q=%0d r=%0d expected 2/0",
                     quotient, remainder);
        end
        lat = 0;
        for (int e = 3; e <= 20; e++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = e;
                break;
            end
        end
        check_result("20/6 ignored start", lat, 5, 5'd3, 5'd2, 1'b0);
        // Still in the done cycle: the next start is accepted immediately.
        do_op(5'd29, 5'd4, lat);
        check_result("29/4 back-to-back", lat, 5, 5'd7, 5'd1, 1'b0);
    endtask

    task automatic test_rst_abort();
        int lat;
        bit saw_done;
        dividend = 5'd30;
        divisor  = 5'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, div_by_zero, quotient, remainder} !== 13'd0) begin
            n_err++;
            $display("FAIL abort outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d expected all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(posedge clk); #1 rst = 1'b0;
        saw_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_err++;
            $display("FAIL abort activity: got %b expected 0", saw_done);
        end
        do_op(5'd30, 5'd7, lat);
        check_result("30/7 after abort", lat, 5, 5'd4, 5'd2, 1'b0);
    endtask

    task automatic test_sweep();
        int lat;
        int q;
        int r;
        for (int a = 0; a < 32; a++) begin
            for (int b = 1; b < 32; b++) begin
                do_op(5'(a), 5'(b), lat);
                q = int'(quotient);
                r = int'(remainder);
                n_cmp++;
                if (lat != 5 || q * b + r != a || r >= b || div_by_zero !== 1'b0) begin
                    n_err++;
                    $display("FAIL sweep %0d/%0d: got q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=5",
                             a, b, q, r, lat, a / b, a % b);
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_basic();
        test_patterns();
        test_div_zero();
        test_start_ignored_and_back_to_back();
        test_rst_abort();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
